// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream engine and its byte-step datapath.
// Contents:
//   crc_state_t   - engine FSM states
//   CRC32_*       - standard CRC-32 constants (normal and reflected polynomial,
//                   init, output XOR, and the check value of "123456789")
//   bit_reverse32 - mirrors a 32-bit value (bit 0 <-> bit 31)
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        SHIFT,
        DONE
    } crc_state_t;

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR_OUT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_CHECK     = 32'hCBF43926;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] value);
        logic [31:0] reversed;
        reversed = '0;
        for (int i = 0; i < 32; i++) begin
            reversed[i] = value[31 - i];
        end
        return reversed;
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte of CRC-32 update, purely combinational.
// Ports:
//   crc_in    - current CRC register
//   data_byte - message byte to fold in
//   reflect   - 1: LSB-first, right shift, reflected polynomial
//               0: MSB-first, left shift, normal polynomial
//   crc_out   - CRC register after all 8 bits of data_byte
// Shared with the CRC check path in the config block.
module crc_byte_step
    import crc_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_byte,
    input  logic        reflect,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = bit_reverse32(POLY);

    logic [31:0] crc_next;
    logic        feedback;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        crc_next = crc_in;
        feedback = 1'b0;
        // NOTE: blocking assignments on purpose -- each bit iteration must see the
        // register value produced by the previous one.
        for (int i = 0; i < 8; i++) begin
            if (reflect) begin
                feedback = crc_next[0] ^ data_byte[i];
                crc_next = crc_next >> 1;
                if (feedback) crc_next = crc_next ^ POLY_REFL;
            end else begin
                feedback = crc_next[31] ^ data_byte[7 - i];
                crc_next = {crc_next[30:0], 1'b0};
                if (feedback) crc_next = crc_next ^ POLY;
            end
        end
    end

    assign crc_out = crc_next;

endmodule

// File: rtl/crc_stream_engine.sv
// Byte-serial CRC engine fed by a valid/ready stream of 32-bit little-endian
// words; presents the final CRC on a valid/ready result handshake.
// Ports:
//   HCLK, RESET        - clock, asynchronous active-low reset
//   start              - pulse: load INIT and begin a new message (aborts any current one)
//   in_valid/in_ready  - word handshake; in_data byte 0 = [7:0] is processed first
//   in_last, in_bytes  - final-word flag and its valid byte count (values >4 mean 4)
//   crc_valid/crc_ready- result handshake; crc_out holds steady while waiting
//   busy               - engine is not idle
// A full word costs one ACCEPT cycle plus one SHIFT cycle per byte.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int              DATA_WIDTH = 32,
    parameter int              CRC_WIDTH  = 32,
    parameter logic [31:0]     POLY       = CRC32_POLY,
    parameter logic [31:0]     INIT       = CRC32_INIT,
    parameter logic [31:0]     XOR_OUT    = CRC32_XOR_OUT,
    parameter int              REFLECT    = 1
) (
    input  logic                  HCLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [2:0]            in_bytes,
    output logic                  crc_valid,
    input  logic                  crc_ready,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  busy
);

    crc_state_t            state;
    logic [CRC_WIDTH-1:0]  crc_reg;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [2:0]            byte_cnt;
    logic                  last_reg;
    logic [CRC_WIDTH-1:0]  step_out;
    logic [2:0]            accept_bytes;

    // Non-final words always carry 4 bytes; a final word's count saturates at 4.
    assign accept_bytes = !in_last           ? 3'd4 :
                          (in_bytes > 3'd4)  ? 3'd4 : in_bytes;

    crc_byte_step #(
        .POLY      (POLY)
    ) u_step (
        .crc_in    (crc_reg),
        .data_byte (word_reg[7:0]),
        .reflect   (REFLECT != 0),
        .crc_out   (step_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge HCLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            crc_reg   <= '0;
            word_reg  <= '0;
            byte_cnt  <= '0;
            last_reg  <= 1'b0;
            in_ready  <= 1'b0;
            crc_valid <= 1'b0;
            crc_out   <= '0;
            busy      <= 1'b0;
        end else if (start) begin
            // start wins over any handshake in the same cycle; a pending result is dropped.
            state     <= ACCEPT;
            crc_reg   <= INIT;
            byte_cnt  <= '0;
            last_reg  <= 1'b0;
            in_ready  <= 1'b1;
            crc_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                end

                ACCEPT: begin
                    if (in_valid && in_ready) begin
                        word_reg <= in_data;
                        last_reg <= in_last;
                        byte_cnt <= accept_bytes;
                        in_ready <= 1'b0;
                        if (in_last && accept_bytes == 3'd0) begin
                            // Empty final word: the register is already final.
                            state     <= DONE;
                            crc_out   <= crc_reg ^ XOR_OUT;
                            crc_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    crc_reg  <= step_out;
                    word_reg <= word_reg >> 8;
                    byte_cnt <= byte_cnt - 3'd1;
                    if (byte_cnt == 3'd1) begin
                        if (last_reg) begin
                            // Result is formed from the step output so it appears
                            // the cycle right after the last byte.
                            state     <= DONE;
                            crc_out   <= step_out ^ XOR_OUT;
                            crc_valid <= 1'b1;
                        end else begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (crc_valid && crc_ready) begin
                        state     <= IDLE;
                        crc_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine. Expected CRCs are queued when a
// message is driven and compared whenever the engine hands over a result.
module tb_crc_stream_engine;
    import crc_pkg::*;

    logic        HCLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        crc_valid;
    logic        crc_ready;
    logic [31:0] crc_out;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] sb[$];

    crc_stream_engine dut (
        .HCLK      (HCLK),
        .RESET     (RESET),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .crc_valid (crc_valid),
        .crc_ready (crc_ready),
        .crc_out   (crc_out),
        .busy      (busy)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference CRC-32 (reflected, textbook bitwise form).
    function automatic logic [31:0] crc32_ref(input logic [7:0] msg[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (msg[k]) begin
            c = c ^ {24'h0, msg[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Result monitor: a handshake happens at the next rising edge.
    always @(negedge HCLK) begin
        if (RESET && crc_valid && crc_ready) begin
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else                check("sb_crc_out", crc_out, sb.pop_front());
        end
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !in_ready; t++) tick;
        if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
        else           tick;
        in_valid = 1'b0;
    endtask

    task automatic send_check_string(input int gap);
        send_word(32'h34333231, 1'b0, 3'd4, gap);
        send_word(32'h38373635, 1'b0, 3'd4, gap);
        send_word(32'h00000039, 1'b1, 3'd1, gap);
    endtask

    task automatic wait_result;
        for (int t = 0; t < 200 && !crc_valid; t++) tick;
        if (!crc_valid) check("result_timeout", {31'b0, crc_valid}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        logic [7:0]  msg[$];
        logic [31:0] w;
        int          len, rem, k;

        RESET = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; in_bytes = '0; crc_ready = 1'b1;
        repeat (3) tick;
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_crc_valid", {31'b0, crc_valid}, 32'd0);
        check("rst_crc_out",   crc_out,            32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        RESET = 1'b1;
        tick;

        // Check string with in_valid held high; latency from the start edge.
        sb.push_back(CRC32_CHECK);
        do_start;
        t0 = cyc;
        check("start_busy", {31'b0, busy}, 32'd1);
        send_check_string(0);
        wait_result;
        check("check_latency", cyc - t0, 32'd12);
        check("check_crc", crc_out, CRC32_CHECK);
        tick;
        check("check_idle_busy", {31'b0, busy}, 32'd0);

        // Empty message: result the cycle after the handshake.
        sb.push_back(32'h00000000);
        do_start;
        send_word(32'hDEADBEEF, 1'b1, 3'd0, 0);
        check("empty_valid", {31'b0, crc_valid}, 32'd1);
        check("empty_crc", crc_out, 32'h00000000);
        tick;

        // Four zero bytes, then the same with an over-range byte count.
        sb.push_back(32'h2144DF1C);
        do_start;
        send_word(32'h00000000, 1'b1, 3'd4, 0);
        wait_result;
        tick;
        sb.push_back(32'h2144DF1C);
        do_start;
        send_word(32'h00000000, 1'b1, 3'd7, 0);
        wait_result;
        check("clamp_crc", crc_out, 32'h2144DF1C);
        tick;

        // Gaps between words plus result backpressure.
        crc_ready = 1'b0;
        sb.push_back(CRC32_CHECK);
        do_start;
        send_check_string(3);
        wait_result;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp_valid",    {31'b0, crc_valid}, 32'd1);
            check("bp_crc",      crc_out,            CRC32_CHECK);
            check("bp_in_ready", {31'b0, in_ready},  32'd0);
        end
        crc_ready = 1'b1;
        tick;
        check("bp_valid_drop", {31'b0, crc_valid}, 32'd0);
        check("bp_busy",       {31'b0, busy},      32'd0);

        // Restart during SHIFT: only the second message completes.
        do_start;
        send_word(32'h34333231, 1'b0, 3'd4, 0);
        tick;
        check("restart_in_shift", {31'b0, in_ready}, 32'd0);
        sb.push_back(CRC32_CHECK);
        do_start;
        check("restart_in_ready", {31'b0, in_ready},  32'd1);
        check("restart_no_valid", {31'b0, crc_valid}, 32'd0);
        send_check_string(0);
        wait_result;
        check("restart_crc", crc_out, CRC32_CHECK);
        tick;

        // Asynchronous reset during SHIFT of word 2.
        do_start;
        send_word(32'h34333231, 1'b0, 3'd4, 0);
        send_word(32'h38373635, 1'b0, 3'd4, 0);
        tick;
        #2 RESET = 1'b0;
        #1;
        check("arst_in_ready",  {31'b0, in_ready},  32'd0);
        check("arst_crc_valid", {31'b0, crc_valid}, 32'd0);
        check("arst_crc_out",   crc_out,            32'd0);
        check("arst_busy",      {31'b0, busy},      32'd0);
        repeat (2) tick;
        RESET = 1'b1;
        tick;
        check("arst_stays_idle", {31'b0, busy}, 32'd0);
        sb.push_back(CRC32_CHECK);
        do_start;
        send_check_string(0);
        wait_result;
        tick;

        // Random messages against the reference model; unused bytes are junk.
        for (int m = 0; m < 4; m++) begin
            msg.delete();
            len = $urandom_range(1, 11);
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            sb.push_back(crc32_ref(msg));
            do_start;
            rem = len;
            k   = 0;
            while (rem > 0) begin
                w = $urandom;
                for (int j = 0; j < 4 && j < rem; j++) w[8*j +: 8] = msg[k + j];
                if (rem <= 4) send_word(w, 1'b1, 3'(rem), $urandom_range(0, 2));
                else          send_word(w, 1'b0, 3'($urandom), $urandom_range(0, 2));
                k   += (rem < 4) ? rem : 4;
                rem -= (rem < 4) ? rem : 4;
            end
            wait_result;
            tick;
        end

        repeat (2) tick;
        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
